// File: rtl/apex7_state_seq_pkg.sv
// Shared types and constants for the apex7 state-register stage: FSM states,
// bit positions of every named signal in the packed state vector, reset value.
package apex7_state_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STATE_W_DEF = 35;

  // Active-high signals in alphabetical order, then the active-low group on top.
  localparam int ACCRPY_IDX  = 0;
  localparam int BULL0_IDX   = 1;
  localparam int BULL1_IDX   = 2;
  localparam int BULL2_IDX   = 3;
  localparam int BULL3_IDX   = 4;
  localparam int BULL4_IDX   = 5;
  localparam int BULL5_IDX   = 6;
  localparam int BULL6_IDX   = 7;
  localparam int COMPPAR_IDX = 8;
  localparam int DEL1_IDX    = 9;
  localparam int END_IDX     = 10;
  localparam int LSD_IDX     = 11;
  localparam int MARSSR_IDX  = 12;
  localparam int OVACC_IDX   = 13;
  localparam int PLUTO0_IDX  = 14;
  localparam int PLUTO1_IDX  = 15;
  localparam int PLUTO2_IDX  = 16;
  localparam int PLUTO3_IDX  = 17;
  localparam int PLUTO4_IDX  = 18;
  localparam int PLUTO5_IDX  = 19;
  localparam int PY_IDX      = 20;
  localparam int RATR_IDX    = 21;
  localparam int STAR0_IDX   = 22;
  localparam int STAR1_IDX   = 23;
  localparam int STAR2_IDX   = 24;
  localparam int STAR3_IDX   = 25;
  localparam int VLENESR_IDX = 26;
  localparam int VST0_IDX    = 27;
  localparam int VST1_IDX    = 28;
  localparam int VSUMESR_IDX = 29;
  localparam int WATCH_IDX   = 30;
  localparam int KBG_N_IDX   = 31;
  localparam int ORWD_N_IDX  = 32;
  localparam int OWL_N_IDX   = 33;
  localparam int VERR_N_IDX  = 34;

  // Every active-low signal starts deasserted (bit set); all others clear.
  localparam logic [STATE_W_DEF-1:0] RST_STATE_DEF =
      (35'(1) << KBG_N_IDX) | (35'(1) << ORWD_N_IDX) |
      (35'(1) << OWL_N_IDX) | (35'(1) << VERR_N_IDX);

endpackage

// File: rtl/apex7_state_seq_trace_fifo.sv
// Circular trace buffer with first-word fall-through; a push into a full
// buffer overwrites the oldest entry so pushes never stall.
module apex7_trace_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk_pad,
  input  logic         rst_n_pad,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_drop;
  logic w_full;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = pop_i && (r_count != '0);
  assign w_drop  = push_i && w_full && !w_pop;
  assign valid_o = (r_count != '0);
  assign data_o  = r_mem[r_rd];

  // NOTE: storage has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk_pad) begin
    if (push_i) r_mem[r_wr] <= push_data_i;
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push_i)          r_wr <= r_wr + 1'b1;
      if (w_pop || w_drop) r_rd <= r_rd + 1'b1;
      unique case ({push_i, w_pop || w_drop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apex7_state_seq.sv
// Present-state register around the apex7 next-state core with run control,
// a saturating step counter and change flag. Define APEX7_STATE_SEQ_TRACE_EN
// to add a trace FIFO of pre-commit states.
module apex7_state_seq
  import apex7_state_pkg::*;
#(
  parameter int                 STATE_W   = STATE_W_DEF,
  parameter logic [STATE_W-1:0] RST_STATE = RST_STATE_DEF,
  parameter int                 MAX_STEPS = 1024,
  parameter int                 CNT_W     = 11
`ifdef APEX7_STATE_SEQ_TRACE_EN
  , parameter int               TRACE_DEPTH = 4
`endif
) (
  input  logic               clk_pad,
  input  logic               rst_n_pad,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               step_valid_i,
  output logic               step_ready_o,
  input  logic [STATE_W-1:0] ns_i,
  output logic [STATE_W-1:0] ps_o,
  output logic [CNT_W-1:0]   step_cnt_o,
  output logic               done_o,
  output logic               changed_o
`ifdef APEX7_STATE_SEQ_TRACE_EN
  , input  logic               trace_pop_i,
  output logic               trace_valid_o,
  output logic [STATE_W-1:0] trace_data_o
`endif
);

  state_e             r_state;
  logic [STATE_W-1:0] r_ps;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_changed;
  logic               w_commit;

  assign step_ready_o = (r_state == RUN);
  assign w_commit     = step_ready_o && step_valid_i;

  assign ps_o       = r_ps;
  assign step_cnt_o = r_cnt;
  assign done_o     = r_done;
  assign changed_o  = r_changed;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_state   <= IDLE;
      r_ps      <= RST_STATE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_changed <= 1'b0;
    end else if (clear_i) begin
      r_state   <= IDLE;
      r_ps      <= RST_STATE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      unique case (r_state)
        IDLE: if (start_i) r_state <= RUN;
        RUN: begin
          // ns_i is only looked at here, so an unknown value outside a commit is harmless.
          if (step_valid_i) begin
            r_ps      <= ns_i;
            r_cnt     <= r_cnt + 1'b1;
            r_changed <= (ns_i != r_ps);
            if (r_cnt == CNT_W'(MAX_STEPS - 1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef APEX7_STATE_SEQ_TRACE_EN
  apex7_trace_fifo #(
    .W     (STATE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk_pad     (clk_pad),
    .rst_n_pad   (rst_n_pad),
    .clear_i     (clear_i),
    .push_i      (w_commit && !clear_i),
    .push_data_i (r_ps),
    .pop_i       (trace_pop_i),
    .valid_o     (trace_valid_o),
    .data_o      (trace_data_o)
  );
`endif

endmodule

// File: tb/tb_apex7_state_seq.sv
// Self-checking bench for apex7_state_seq: directed vector table, hand-written
// corner sequences, and randomized traffic against a history-based model.
`timescale 1ns/1ps
module tb_apex7_state_seq;

  localparam int W      = 35;
  localparam int MAXS   = 8;
  localparam int CW     = 4;
  localparam int TDEPTH = 4;
  localparam logic [W-1:0] RST = 35'h7_8000_0000;

  logic          clk_pad = 1'b0;
  logic          rst_n_pad;
  logic          start_i, clear_i, step_valid_i;
  logic          step_ready_o;
  logic [W-1:0]  ns_i;
  logic [W-1:0]  ps_o;
  logic [CW-1:0] step_cnt_o;
  logic          done_o, changed_o;
`ifdef APEX7_STATE_SEQ_TRACE_EN
  logic          trace_pop_i;
  logic          trace_valid_o;
  logic [W-1:0]  trace_data_o;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_pad = ~clk_pad;

  apex7_state_seq #(
    .STATE_W   (W),
    .MAX_STEPS (MAXS),
    .CNT_W     (CW)
`ifdef APEX7_STATE_SEQ_TRACE_EN
    , .TRACE_DEPTH (TDEPTH)
`endif
  ) dut (
    .clk_pad      (clk_pad),
    .rst_n_pad    (rst_n_pad),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .step_valid_i (step_valid_i),
    .step_ready_o (step_ready_o),
    .ns_i         (ns_i),
    .ps_o         (ps_o),
    .step_cnt_o   (step_cnt_o),
    .done_o       (done_o),
    .changed_o    (changed_o)
`ifdef APEX7_STATE_SEQ_TRACE_EN
    , .trace_pop_i   (trace_pop_i),
    .trace_valid_o (trace_valid_o),
    .trace_data_o  (trace_data_o)
`endif
  );

  typedef struct {
    logic         start;
    logic         clear;
    logic         valid;
    logic [W-1:0] ns;
    logic [W-1:0] ps;
    int           cnt;
    logic         ready;
    logic         done;
    logic         chg;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] ps, input int cnt,
                           input logic ready, input logic done, input logic chg);
    check({tag, ".ps"},    64'(ps_o),         64'(ps));
    check({tag, ".cnt"},   64'(step_cnt_o),   64'(cnt));
    check({tag, ".ready"}, 64'(step_ready_o), 64'(ready));
    check({tag, ".done"},  64'(done_o),       64'(done));
    check({tag, ".chg"},   64'(changed_o),    64'(chg));
  endtask

  task automatic tick();
    @(posedge clk_pad);
    #1;
  endtask

  function automatic void add(input logic st, input logic cl, input logic v, input logic [W-1:0] ns,
                              input logic [W-1:0] ps, input int cnt, input logic rdy,
                              input logic dn, input logic ch);
    vec_t e;
    e.start = st; e.clear = cl; e.valid = v; e.ns = ns;
    e.ps = ps; e.cnt = cnt; e.ready = rdy; e.done = dn; e.chg = ch;
    tbl.push_back(e);
  endfunction

  // Reference model: the committed values so far; ps, count and done follow from it.
  logic [W-1:0] hist[$];
  logic [W-1:0] trq[$];
  bit           started;
  bit           m_chg;

  function automatic logic [W-1:0] model_ps();
    return (hist.size() == 0) ? RST : hist[hist.size()-1];
  endfunction

  initial begin
    logic [63:0]  rnd;
    logic [W-1:0] pre;
    bit           ready_now, commit;

    rst_n_pad = 1'b0; start_i = 0; clear_i = 0; step_valid_i = 0; ns_i = '0;
`ifdef APEX7_STATE_SEQ_TRACE_EN
    trace_pop_i = 0;
`endif
    repeat (3) @(posedge clk_pad);
    #1;
    check_all("rst_hold", RST, 0, 0, 0, 0);
    @(negedge clk_pad);
    rst_n_pad = 1'b1;
    tick();
    check_all("rst_rel", RST, 0, 0, 0, 0);

    //  st cl v  ns        ps      cnt rdy dn ch
    add(1, 0, 1, 35'h9,    RST,    0,  1,  0, 0);  // start+valid in IDLE: no commit
    add(0, 0, 1, 35'h1,    35'h1,  1,  1,  0, 1);
    add(0, 0, 1, 35'h1,    35'h1,  2,  1,  0, 0);
    add(0, 0, 1, 35'h1,    35'h1,  3,  1,  0, 0);
    add(0, 0, 0, 'x,       35'h1,  3,  1,  0, 0);  // unknown ns without commit
    add(1, 0, 1, 35'h1,    35'h1,  4,  1,  0, 0);  // start ignored in RUN
    add(0, 0, 1, 35'h6,    35'h6,  5,  1,  0, 1);
    add(0, 0, 1, 35'h7,    35'h7,  6,  1,  0, 1);
    add(0, 0, 1, 35'h7,    35'h7,  7,  1,  0, 0);
    add(0, 0, 1, 35'h2,    35'h2,  8,  0,  1, 1);  // final commit -> DONE
    add(0, 0, 1, 35'h7,    35'h2,  8,  0,  1, 0);  // frozen
    add(1, 0, 1, 35'h7,    35'h2,  8,  0,  1, 0);  // start ignored in DONE
    add(0, 1, 0, 35'h0,    RST,    0,  0,  0, 0);  // clear from DONE
    add(1, 0, 0, 35'h0,    RST,    0,  1,  0, 0);
    add(0, 0, 1, 35'h3,    35'h3,  1,  1,  0, 1);
    add(0, 0, 1, 35'h4,    35'h4,  2,  1,  0, 1);
    add(0, 1, 1, 35'h5,    RST,    0,  0,  0, 0);  // clear beats commit at count 2
    add(1, 1, 0, 35'h0,    RST,    0,  0,  0, 0);  // clear beats start
    add(0, 0, 1, 35'h8,    RST,    0,  0,  0, 0);  // valid in IDLE ignored

    for (int i = 0; i < tbl.size(); i++) begin
      start_i = tbl[i].start; clear_i = tbl[i].clear;
      step_valid_i = tbl[i].valid; ns_i = tbl[i].ns;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].ps, tbl[i].cnt, tbl[i].ready, tbl[i].done, tbl[i].chg);
    end

    // Asynchronous reset in the middle of a run at count 7.
    start_i = 1; clear_i = 0; step_valid_i = 0;
    tick();
    start_i = 0; step_valid_i = 1;
    for (int k = 1; k <= 7; k++) begin
      ns_i = W'(k * 3);
      tick();
    end
    check("arst.pre_cnt", 64'(step_cnt_o), 64'd7);
    ns_i = 35'h5a5;
    #2 rst_n_pad = 1'b0;
    #1;
    check_all("arst", RST, 0, 0, 0, 0);
    @(negedge clk_pad);
    rst_n_pad = 1'b1;
    step_valid_i = 0;
    tick();
    check_all("arst_rel", RST, 0, 0, 0, 0);

`ifdef APEX7_STATE_SEQ_TRACE_EN
    check("trace.empty_rst", 64'(trace_valid_o), 64'd0);
    start_i = 1;
    tick();
    start_i = 0; step_valid_i = 1;
    for (int k = 1; k <= 6; k++) begin
      ns_i = W'(k);
      tick();
    end
    step_valid_i = 0;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("trace.valid%0d", k), 64'(trace_valid_o), 64'd1);
      check($sformatf("trace.data%0d", k),  64'(trace_data_o),  64'(k));
      trace_pop_i = 1;
      tick();
      trace_pop_i = 0;
    end
    check("trace.drained", 64'(trace_valid_o), 64'd0);
    trace_pop_i = 1;
    tick();
    trace_pop_i = 0;
    check("trace.pop_empty", 64'(trace_valid_o), 64'd0);
`endif

    // Randomized traffic against the history model, starting from a clear.
    clear_i = 1; start_i = 0; step_valid_i = 0;
    tick();
    hist.delete(); trq.delete(); started = 0; m_chg = 0;
    check_all("rnd_init", RST, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      rnd = {$urandom, $urandom};
      start_i      = ($urandom_range(3) == 0);
      clear_i      = ($urandom_range(40) == 0);
      step_valid_i = $urandom_range(1);
      ns_i         = ($urandom_range(3) == 0) ? model_ps() : rnd[W-1:0];
`ifdef APEX7_STATE_SEQ_TRACE_EN
      trace_pop_i  = ($urandom_range(2) == 0);
`endif
      ready_now = started && (hist.size() < MAXS);
      pre = model_ps();
      if (clear_i) begin
        hist.delete(); trq.delete(); started = 0; m_chg = 0;
      end else begin
        commit = ready_now && step_valid_i;
`ifdef APEX7_STATE_SEQ_TRACE_EN
        if (trace_pop_i && trq.size() > 0) void'(trq.pop_front());
        if (commit) trq.push_back(pre);
        if (trq.size() > TDEPTH) void'(trq.pop_front());
`endif
        m_chg = commit && (ns_i != pre);
        if (commit) hist.push_back(ns_i);
        if (!started && start_i) started = 1;
      end
      tick();
      check_all($sformatf("rnd%0d", i), model_ps(), hist.size(),
                started && (hist.size() < MAXS), hist.size() == MAXS, m_chg);
`ifdef APEX7_STATE_SEQ_TRACE_EN
      check($sformatf("rnd%0d.tvalid", i), 64'(trace_valid_o), 64'(trq.size() > 0));
      if (trq.size() > 0) check($sformatf("rnd%0d.tdata", i), 64'(trace_data_o), 64'(trq[0]));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
